// File: rtl/decoder_sweep_pkg.sv
// Shared types and helpers for the decoder_sweep block.
// - state_e  : sweep controller states (IDLE, SWEEP)
// - DWELL_W  : width of the per-index dwell counter
// - onehot() : returns a vector with only bit idx set (all-zero if idx >= width)
package decoder_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam int DWELL_W    = 8;
  localparam int MAX_ADDR_W = 10;
  localparam int MAX_OUT_W  = 2 ** MAX_ADDR_W;

  // Callers truncate the wide result down to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx, input int unsigned width);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    if ((idx < width) && (idx < MAX_OUT_W)) begin
      r[idx[MAX_ADDR_W-1:0]] = 1'b1;
    end else begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_sweep_if.sv
// Control/result bundle between the write-select controller and decoder_sweep.
// master : drives dec_en, S, start, abort; observes the decode results.
// slave  : the decoder itself.
interface decoder_sweep_if #(
  parameter int ADDR_W = 5
);
  localparam int OUT_W = 2 ** ADDR_W;

  logic              dec_en;
  logic [ADDR_W-1:0] S;
  logic              start;
  logic              abort;
  logic [OUT_W-1:0]  m;
  logic              m_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_idx;

  modport master (
    output dec_en, S, start, abort,
    input  m, m_valid, busy, done, cur_idx
  );

  modport slave (
    input  dec_en, S, start, abort,
    output m, m_valid, busy, done, cur_idx
  );
endinterface

// File: rtl/decoder_sweep_decoder_n.sv
// Combinational ADDR_W-to-2**ADDR_W one-hot decoder with enable.
// en_i : when 0 the output is all-zero
// a_i  : index to decode
// y_o  : one-hot (or zero) result
module decoder_n
  import decoder_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic                 en_i,
  input  logic [ADDR_W-1:0]    a_i,
  output logic [2**ADDR_W-1:0] y_o
);
  localparam int OUT_W = 2 ** ADDR_W;

  // One-hot decode of a_i, gated by the enable.
  always_comb begin
    if (en_i) begin
      y_o = OUT_W'(onehot(32'(a_i), 32'(OUT_W)));
    end else begin
      y_o = '0;
    end
  end
endmodule

// File: rtl/decoder_sweep.sv
// Registered one-hot decoder with a direct mode and a self-timed sweep mode.
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : slave side of decoder_sweep_if (dec_en, S, start, abort in;
//         m, m_valid, busy, done, cur_idx out, all registered)
module decoder_sweep
  import decoder_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int STEP      = 1,
  parameter int MASK_ZERO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  decoder_sweep_if.slave bus
);
  localparam int OUT_W = 2 ** ADDR_W;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(STEP - 1);
  localparam logic [ADDR_W-1:0]  IDX_FIRST  = (MASK_ZERO != 0) ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0]  IDX_LAST   = ADDR_W'(OUT_W - 1);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [OUT_W-1:0]   m_q, m_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dec_go_s;
  logic               zero_mask_s;

  // The decoder works on the next index so m lines up with cur_idx after the edge.
  assign zero_mask_s = (MASK_ZERO != 0) && (idx_d == '0);

  decoder_n #(.ADDR_W(ADDR_W)) u_dec (
    .en_i (dec_go_s & ~zero_mask_s),
    .a_i  (idx_d),
    .y_o  (m_d)
  );

  // Next-state and output logic for the IDLE/SWEEP controller.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = '0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dec_go_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SWEEP;
          idx_d    = IDX_FIRST;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          dec_go_s = 1'b1;
        end else if (bus.dec_en) begin
          idx_d    = bus.S;
          valid_d  = 1'b1;
          dec_go_s = 1'b1;
        end else begin
          idx_d    = '0;
        end
      end
      SWEEP: begin
        // abort wins over a completion landing in the same cycle
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == DWELL_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d    = idx_q + ADDR_W'(1);
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            dec_go_s = 1'b1;
          end
        end else begin
          cnt_d    = cnt_q + DWELL_W'(1);
          idx_d    = idx_q;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          dec_go_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      m_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.m       = m_q;
  assign bus.m_valid = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cur_idx = idx_q;
endmodule

// File: tb/tb_decoder_sweep.sv
// Self-checking bench for decoder_sweep: two instances (STEP=2/MASK_ZERO=0 and
// STEP=1/MASK_ZERO=1) against a cycle-count based behavioural model.
module tb_decoder_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decoder_sweep_if #(.ADDR_W(5)) ifa ();
  decoder_sweep_if #(.ADDR_W(5)) ifb ();

  decoder_sweep #(.ADDR_W(5), .STEP(2), .MASK_ZERO(0)) u_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa)
  );
  decoder_sweep #(.ADDR_W(5), .STEP(1), .MASK_ZERO(1)) u_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb)
  );

  // Model: a sweep is "t cycles since its first index appeared"; direct mode
  // remembers the last select.
  typedef struct {
    bit sw;
    int t;
    bit dv;
    int ds;
    bit d;
  } model_t;

  typedef struct {
    logic [31:0] m;
    logic        v;
    logic        b;
    logic        d;
    logic [4:0]  idx;
  } exp_t;

  model_t ma, mb;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_clear();
    model_t md;
    md.sw = 1'b0; md.t = 0; md.dv = 1'b0; md.ds = 0; md.d = 1'b0;
    return md;
  endfunction

  task automatic mstep(inout model_t md, input int step, input bit mz,
                       input logic en, input logic [4:0] s, input logic st, input logic ab);
    int n;
    n = mz ? 31 : 32;
    md.d = 1'b0;
    if (md.sw) begin
      md.dv = 1'b0;
      if (ab) begin
        md.sw = 1'b0;
      end else begin
        md.t++;
        if (md.t >= n * step) begin
          md.sw = 1'b0;
          md.d  = 1'b1;
        end
      end
    end else if (st) begin
      md.sw = 1'b1; md.t = 0; md.dv = 1'b0;
    end else begin
      md.dv = en; md.ds = int'(s);
    end
  endtask

  function automatic exp_t expect_out(model_t md, int step, bit mz);
    exp_t e;
    int first;
    first = mz ? 1 : 0;
    e.m = 32'h0; e.v = 1'b0; e.b = 1'b0; e.idx = 5'd0;
    e.d = md.d;
    if (md.sw) begin
      e.idx = 5'(first + md.t / step);
      e.m   = 32'h1 << e.idx;
      e.v   = 1'b1;
      e.b   = 1'b1;
    end else if (md.dv) begin
      e.idx = 5'(md.ds);
      e.m   = (mz && md.ds == 0) ? 32'h0 : (32'h1 << md.ds);
      e.v   = 1'b1;
    end
    return e;
  endfunction

  task automatic check_dut(input string p, input exp_t e, input logic [31:0] m, input logic v,
                           input logic b, input logic d, input logic [4:0] idx);
    check_eq({p, ".m"}, m, e.m);
    check_eq({p, ".m_valid"}, 32'(v), 32'(e.v));
    check_eq({p, ".busy"}, 32'(b), 32'(e.b));
    check_eq({p, ".done"}, 32'(d), 32'(e.d));
    check_eq({p, ".cur_idx"}, 32'(idx), 32'(e.idx));
    check_eq({p, ".onehot"}, 32'($countones(m) <= 1), 32'd1);
  endtask

  task automatic check_all();
    check_dut("A", expect_out(ma, 2, 1'b0), ifa.m, ifa.m_valid, ifa.busy, ifa.done, ifa.cur_idx);
    check_dut("B", expect_out(mb, 1, 1'b1), ifb.m, ifb.m_valid, ifb.busy, ifb.done, ifb.cur_idx);
  endtask

  task automatic set_a(input logic en, input logic [4:0] s, input logic st, input logic ab);
    ifa.dec_en = en; ifa.S = s; ifa.start = st; ifa.abort = ab;
  endtask

  task automatic set_b(input logic en, input logic [4:0] s, input logic st, input logic ab);
    ifb.dec_en = en; ifb.S = s; ifb.start = st; ifb.abort = ab;
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare.
  task automatic cycle();
    @(posedge clk);
    mstep(ma, 2, 1'b0, ifa.dec_en, ifa.S, ifa.start, ifa.abort);
    mstep(mb, 1, 1'b1, ifb.dec_en, ifb.S, ifb.start, ifb.abort);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    ma = model_clear();
    mb = model_clear();
    check_all();
    set_a(1'b0, 5'd0, 1'b0, 1'b0);
    set_b(1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    ma = model_clear();
    mb = model_clear();
    set_a(1'b0, 5'd0, 1'b0, 1'b0);
    set_b(1'b0, 5'd0, 1'b0, 1'b0);

    // Reset between edges, no clock edge needed.
    #2;
    async_reset();

    // Direct mode: walk every select.
    for (int s = 0; s < 32; s++) begin
      set_a(1'b1, 5'(s), 1'b0, 1'b0);
      set_b(1'b1, 5'(s), 1'b0, 1'b0);
      cycle();
      check_eq("dir_const_A", ifa.m, 32'h1 << s);
    end
    set_a(1'b0, 5'd3, 1'b0, 1'b0);
    set_b(1'b0, 5'd3, 1'b0, 1'b0);
    cycle();
    check_eq("dir_off_A", ifa.m, 32'h0);

    // start beats dec_en; select ignored during the sweep.
    set_a(1'b1, 5'd7, 1'b1, 1'b0);
    set_b(1'b1, 5'd7, 1'b1, 1'b0);
    cycle();
    check_eq("prio_A", ifa.m, 32'h1);
    check_eq("prio_B", ifb.m, 32'h2);
    for (int i = 0; i < 70; i++) begin
      set_a(1'($urandom), 5'($urandom), 1'b0, 1'b0);
      set_b(1'($urandom), 5'($urandom), 1'b0, 1'b0);
      cycle();
      if (i == 30) check_eq("b_done_k32", 32'(ifb.done), 32'd1);
      if (i == 63) check_eq("a_done_k65", 32'(ifa.done), 32'd1);
    end

    // Restart on the done cycle, then abort at cur_idx 4.
    set_a(1'b0, 5'd0, 1'b1, 1'b0);
    set_b(1'b0, 5'd0, 1'b0, 1'b0);
    cycle();
    set_a(1'b0, 5'd0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      found = ma.d;
    end
    check_eq("done_seen", 32'(found), 32'd1);
    set_a(1'b0, 5'd0, 1'b1, 1'b0);
    cycle();
    check_eq("restart_busy", 32'(ifa.busy), 32'd1);
    set_a(1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle();
    check_eq("pre_abort_idx", 32'(ifa.cur_idx), 32'd4);
    set_a(1'b0, 5'd0, 1'b0, 1'b1);
    cycle();
    check_eq("abort_m", ifa.m, 32'h0);
    check_eq("abort_busy", 32'(ifa.busy), 32'd0);
    set_a(1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) cycle();
    set_a(1'b0, 5'd0, 1'b1, 1'b0);
    cycle();
    check_eq("restart_idx0", ifa.m, 32'h1);
    set_a(1'b0, 5'd0, 1'b0, 1'b0);

    // Randomised traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      set_a(1'($urandom), 5'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0));
      set_b(1'($urandom), 5'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0));
      cycle();
    end

    // Reset in the middle of a sweep.
    set_a(1'b0, 5'd0, 1'b1, 1'b0);
    set_b(1'b0, 5'd0, 1'b1, 1'b0);
    cycle();
    set_a(1'b0, 5'd0, 1'b0, 1'b0);
    set_b(1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    async_reset();
    for (int i = 0; i < 3; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
